// File: rtl/and2_chain_driver.sv
// and2_chain_driver: stimulus source and response checker for the "main"
// and2-chain netlist. Walks I = 0..3 for ITERS passes, samples O/O1 after
// SETTLE idle cycles, counts mismatches against O = I[0] & I[1],
// O1 = {O, O}, and reports the result through a start/busy/done handshake.
// Optional feature macro: AND2_CHAIN_DRIVER_FIRST_FAIL_EN adds
// first_fail_valid / first_fail_vec (first mismatching vector of a run).
module and2_chain_driver #(
   parameter int unsigned ITERS  = 1,
   parameter int unsigned SETTLE = 1
) (
   input  logic       CLK,
   input  logic       ASYNCRESETN,
   input  logic       start,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [7:0] err_count,
   output logic [1:0] dut_I,
   input  logic       dut_O,
   input  logic [1:0] dut_O1
`ifdef AND2_CHAIN_DRIVER_FIRST_FAIL_EN
   ,
   output logic       first_fail_valid,
   output logic [1:0] first_fail_vec
`endif
);

   localparam int unsigned CNT_W = 8;
   localparam int unsigned SET_W = 4;
   localparam int unsigned VEC_W = 2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_DRIVE,
      S_SETTLE,
      S_SAMPLE,
      S_DONE
   } state_t;

   state_t             state;
   logic [VEC_W-1:0]   vec_idx;
   logic [CNT_W-1:0]   iter_cnt;
   logic [SET_W-1:0]   settle_cnt;

   logic               exp_o_c;
   logic               mismatch_c;
   logic               last_vec_c;
   logic [CNT_W-1:0]   err_next_c;

   // The vector index is what drives the DUT; it only moves on entry to DRIVE.
   assign dut_I = vec_idx;

   // Golden response, per-vector compare and the saturated error count after this SAMPLE.
   always_comb begin
      exp_o_c    = vec_idx[0] & vec_idx[1];
      mismatch_c = (dut_O != exp_o_c) || (dut_O1 != {exp_o_c, exp_o_c});
      last_vec_c = (vec_idx == VEC_W'(3)) && (iter_cnt == CNT_W'(ITERS - 1));
      err_next_c = err_count;
      if (mismatch_c && (err_count != {CNT_W{1'b1}})) begin
         err_next_c = err_count + CNT_W'(1);
      end
   end

   // Sequencer: state, handshake outputs, counters and error bookkeeping.
   always_ff @(posedge CLK or negedge ASYNCRESETN) begin
      if (!ASYNCRESETN) begin
         state            <= S_IDLE;
         busy             <= 1'b0;
         done             <= 1'b0;
         pass             <= 1'b0;
         err_count        <= '0;
         vec_idx          <= '0;
         iter_cnt         <= '0;
         settle_cnt       <= '0;
`ifdef AND2_CHAIN_DRIVER_FIRST_FAIL_EN
         first_fail_valid <= 1'b0;
         first_fail_vec   <= '0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  err_count        <= '0;
                  pass             <= 1'b0;
                  vec_idx          <= '0;
                  iter_cnt         <= '0;
                  busy             <= 1'b1;
                  state            <= S_DRIVE;
`ifdef AND2_CHAIN_DRIVER_FIRST_FAIL_EN
                  first_fail_valid <= 1'b0;
                  first_fail_vec   <= '0;
`endif
               end
            end
            S_DRIVE: begin
               settle_cnt <= SET_W'(SETTLE);
               state      <= (SETTLE == 0) ? S_SAMPLE : S_SETTLE;
            end
            S_SETTLE: begin
               settle_cnt <= settle_cnt - SET_W'(1);
               if (settle_cnt <= SET_W'(1)) begin
                  state <= S_SAMPLE;
               end
            end
            S_SAMPLE: begin
               err_count <= err_next_c;
`ifdef AND2_CHAIN_DRIVER_FIRST_FAIL_EN
               if (mismatch_c && !first_fail_valid) begin
                  first_fail_valid <= 1'b1;
                  first_fail_vec   <= vec_idx;
               end
`endif
               if (last_vec_c) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= (err_next_c == '0);
                  state <= S_DONE;
               end else begin
                  vec_idx <= vec_idx + VEC_W'(1);
                  if (vec_idx == VEC_W'(3)) begin
                     iter_cnt <= iter_cnt + CNT_W'(1);
                  end
                  state <= S_DRIVE;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_and2_chain_driver.sv
// Bench for and2_chain_driver: four instances with different ITERS/SETTLE,
// each fed by a per-run response table standing in for the "main" netlist.
module tb_and2_chain_driver;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic       start_s [4];
   logic       busy_s  [4];
   logic       done_s  [4];
   logic       pass_s  [4];
   logic [7:0] err_s   [4];
   logic [1:0] dut_i_s [4];
   logic       o_s     [4];
   logic [1:0] o1_s    [4];
   logic [11:0] resp   [4];   // {O,O1} for vector v lives at bits [3v+2:3v]
`ifdef AND2_CHAIN_DRIVER_FIRST_FAIL_EN
   logic       ffv_s   [4];
   logic [1:0] ffvec_s [4];
`endif

   int n_tests = 0;
   int n_fail  = 0;

   function automatic logic [2:0] pick(input logic [11:0] t, input logic [1:0] v);
      case (v)
         2'd0:    return t[2:0];
         2'd1:    return t[5:3];
         2'd2:    return t[8:6];
         default: return t[11:9];
      endcase
   endfunction

   function automatic int iters_of(input int k);
      case (k)
         0: return 1;
         1: return 2;
         2: return 255;
         default: return 1;
      endcase
   endfunction

   function automatic int settle_of(input int k);
      case (k)
         0: return 1;
         1: return 2;
         default: return 0;
      endcase
   endfunction

   // Reference: only vector 3 drives O high, O1 copies O on both bits.
   function automatic logic [2:0] golden(input int v);
      return (v == 3) ? 3'b111 : 3'b000;
   endfunction

   function automatic int model_bad(input logic [11:0] t);
      int bad = 0;
      for (int v = 0; v < 4; v++) if (pick(t, 2'(v)) != golden(v)) bad++;
      return bad;
   endfunction

   function automatic int model_err(input logic [11:0] t, input int iters);
      int e = model_bad(t) * iters;
      return (e > 255) ? 255 : e;
   endfunction

   function automatic int model_ffvec(input logic [11:0] t);
      for (int v = 0; v < 4; v++) if (pick(t, 2'(v)) != golden(v)) return v;
      return 0;
   endfunction

   assign {o_s[0], o1_s[0]} = pick(resp[0], dut_i_s[0]);
   assign {o_s[1], o1_s[1]} = pick(resp[1], dut_i_s[1]);
   assign {o_s[2], o1_s[2]} = pick(resp[2], dut_i_s[2]);
   assign {o_s[3], o1_s[3]} = pick(resp[3], dut_i_s[3]);

   and2_chain_driver #(.ITERS(1), .SETTLE(1)) u_a (
      .CLK(clk), .ASYNCRESETN(rst_n), .start(start_s[0]), .busy(busy_s[0]),
      .done(done_s[0]), .pass(pass_s[0]), .err_count(err_s[0]), .dut_I(dut_i_s[0]),
      .dut_O(o_s[0]), .dut_O1(o1_s[0])
`ifdef AND2_CHAIN_DRIVER_FIRST_FAIL_EN
      , .first_fail_valid(ffv_s[0]), .first_fail_vec(ffvec_s[0])
`endif
   );

   and2_chain_driver #(.ITERS(2), .SETTLE(2)) u_b (
      .CLK(clk), .ASYNCRESETN(rst_n), .start(start_s[1]), .busy(busy_s[1]),
      .done(done_s[1]), .pass(pass_s[1]), .err_count(err_s[1]), .dut_I(dut_i_s[1]),
      .dut_O(o_s[1]), .dut_O1(o1_s[1])
`ifdef AND2_CHAIN_DRIVER_FIRST_FAIL_EN
      , .first_fail_valid(ffv_s[1]), .first_fail_vec(ffvec_s[1])
`endif
   );

   and2_chain_driver #(.ITERS(255), .SETTLE(0)) u_c (
      .CLK(clk), .ASYNCRESETN(rst_n), .start(start_s[2]), .busy(busy_s[2]),
      .done(done_s[2]), .pass(pass_s[2]), .err_count(err_s[2]), .dut_I(dut_i_s[2]),
      .dut_O(o_s[2]), .dut_O1(o1_s[2])
`ifdef AND2_CHAIN_DRIVER_FIRST_FAIL_EN
      , .first_fail_valid(ffv_s[2]), .first_fail_vec(ffvec_s[2])
`endif
   );

   and2_chain_driver #(.ITERS(1), .SETTLE(0)) u_d (
      .CLK(clk), .ASYNCRESETN(rst_n), .start(start_s[3]), .busy(busy_s[3]),
      .done(done_s[3]), .pass(pass_s[3]), .err_count(err_s[3]), .dut_I(dut_i_s[3]),
      .dut_O(o_s[3]), .dut_O1(o1_s[3])
`ifdef AND2_CHAIN_DRIVER_FIRST_FAIL_EN
      , .first_fail_valid(ffv_s[3]), .first_fail_vec(ffvec_s[3])
`endif
   );

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // One full run on instance k; optionally re-pulses start mid-run and in DONE.
   task automatic run_check(input int k, input int exp_err, input bit exp_pass,
                            input bit exp_ffv, input int exp_ffvec,
                            input bit repulse, input string tag);
      int st, len, busy_cyc, done_cnt, late_busy;
      bit seq_ok;
      st        = settle_of(k);
      len       = iters_of(k) * 4 * (st + 2);
      busy_cyc  = 0;
      done_cnt  = 0;
      late_busy = 0;
      seq_ok    = 1'b1;
      @(negedge clk); start_s[k] = 1'b1;
      @(negedge clk); start_s[k] = 1'b0;
      for (int c = 0; c < len + 16; c++) begin
         if (!busy_s[k]) break;
         if (dut_i_s[k] != 2'((c / (st + 2)) % 4)) seq_ok = 1'b0;
         if (done_s[k]) done_cnt++;
         busy_cyc++;
         start_s[k] = repulse && (c == 3);
         @(negedge clk);
      end
      for (int c = 0; c < 4; c++) begin
         if (done_s[k]) done_cnt++;
         if (busy_s[k]) late_busy++;
         start_s[k] = repulse && (c == 0);
         @(negedge clk);
      end
      start_s[k] = 1'b0;
      check($sformatf("%s/busy_cycles", tag), busy_cyc, len);
      check($sformatf("%s/dut_I_seq", tag), int'(seq_ok), 1);
      check($sformatf("%s/done_pulses", tag), done_cnt, 1);
      check($sformatf("%s/busy_after_done", tag), late_busy, 0);
      check($sformatf("%s/err_count", tag), int'(err_s[k]), exp_err);
      check($sformatf("%s/pass", tag), int'(pass_s[k]), int'(exp_pass));
`ifdef AND2_CHAIN_DRIVER_FIRST_FAIL_EN
      check($sformatf("%s/ff_valid", tag), int'(ffv_s[k]), int'(exp_ffv));
      if (exp_ffv) check($sformatf("%s/ff_vec", tag), int'(ffvec_s[k]), exp_ffvec);
`endif
   endtask

   task automatic pulse_start(input int k);
      @(negedge clk); start_s[k] = 1'b1;
      @(negedge clk); start_s[k] = 1'b0;
   endtask

   task automatic wait_idle(input int k, input string tag);
      for (int c = 0; c < 200; c++) begin
         if (!busy_s[k]) break;
         @(negedge clk);
      end
      check($sformatf("%s/wait_idle", tag), int'(busy_s[k]), 0);
      @(negedge clk);
      @(negedge clk);
   endtask

   typedef struct {
      logic [11:0] resp;
      int          err;
      bit          pass;
      bit          ffv;
      int          ffvec;
   } vec_t;

   vec_t tab [6];

   initial begin
      int dn;
      bit found;

      tab[0] = '{12'hE00, 0, 1'b1, 1'b0, 0};   // correct DUT
      tab[1] = '{12'h600, 1, 1'b0, 1'b1, 3};   // O stuck at 0
      tab[2] = '{12'hA49, 4, 1'b0, 1'b1, 0};   // O1 forced to 2'b01
      tab[3] = '{12'h1FF, 4, 1'b0, 1'b1, 0};   // every output inverted
      tab[4] = '{12'hE10, 1, 1'b0, 1'b1, 1};   // O1[1] high on vector 1
      tab[5] = '{12'hF00, 1, 1'b0, 1'b1, 2};   // O high on vector 2 only

      for (int k = 0; k < 4; k++) begin
         start_s[k] = 1'b0;
         resp[k]    = 12'hE00;
      end
      rst_n = 1'b0;
      #12;
      check("reset/busy", int'(busy_s[0]), 0);
      check("reset/done", int'(done_s[0]), 0);
      check("reset/pass", int'(pass_s[0]), 0);
      check("reset/err_count", int'(err_s[0]), 0);
      check("reset/dut_I", int'(dut_i_s[0]), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Table-driven runs on ITERS=1, SETTLE=1
      for (int i = 0; i < 6; i++) begin
         resp[0] = tab[i].resp;
         run_check(0, tab[i].err, tab[i].pass, tab[i].ffv, tab[i].ffvec, 1'b0,
                   $sformatf("tab%0d", i));
      end

      // O stuck at 0 over two passes
      resp[1] = 12'h600;
      run_check(1, 2, 1'b0, 1'b1, 3, 1'b0, "stuck_iters2");

      // SETTLE=0 with O1 forced to 01
      resp[3] = 12'hA49;
      run_check(3, 4, 1'b0, 1'b1, 0, 1'b0, "settle0_o1");

      // Saturation: 255 passes, all outputs inverted
      resp[2] = 12'h1FF;
      run_check(2, 255, 1'b0, 1'b1, 0, 1'b0, "saturate");

      // start re-pulsed mid-run and during DONE
      resp[0] = 12'hE00;
      run_check(0, 0, 1'b1, 1'b0, 0, 1'b1, "repulse");

      // A new start clears err_count, then clears pass
      resp[0] = 12'h600;
      run_check(0, 1, 1'b0, 1'b1, 3, 1'b0, "pre_clear");
      resp[0] = 12'hE00;
      pulse_start(0);
      check("clear/err_count", int'(err_s[0]), 0);
      wait_idle(0, "clear_err");
      check("clear/pass_set", int'(pass_s[0]), 1);
      pulse_start(0);
      check("clear/pass", int'(pass_s[0]), 0);
      wait_idle(0, "clear_pass");

      // Asynchronous reset during SETTLE of vector 2
      pulse_start(0);
      found = 1'b0;
      for (int c = 0; c < 40; c++) begin
         if (dut_i_s[0] == 2'd2) begin
            found = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check("rst_mid/reach_vec2", int'(found), 1);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("rst_mid/busy", int'(busy_s[0]), 0);
      check("rst_mid/dut_I", int'(dut_i_s[0]), 0);
      check("rst_mid/done", int'(done_s[0]), 0);
      check("rst_mid/err_count", int'(err_s[0]), 0);
      check("rst_mid/pass", int'(pass_s[0]), 0);
      @(negedge clk);
      rst_n = 1'b1;
      dn = 0;
      for (int c = 0; c < 8; c++) begin
         if (done_s[0] || busy_s[0]) dn++;
         @(negedge clk);
      end
      check("rst_mid/quiet_after", dn, 0);
      run_check(0, 0, 1'b1, 1'b0, 0, 1'b0, "post_reset");

      // Randomized response tables against the reference model
      for (int r = 0; r < 12; r++) begin
         int pk, k, e;
         logic [11:0] t;
         pk = int'($urandom_range(0, 2));
         k  = (pk == 2) ? 3 : pk;
         t  = 12'($urandom);
         resp[k] = t;
         e = model_err(t, iters_of(k));
         run_check(k, e, e == 0, model_bad(t) != 0, model_ffvec(t), 1'b0,
                   $sformatf("rand%0d_k%0d", r, k));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
